// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions: exception code width, CP0 ExcCode values, Tnew default width.
// Used by the stage registers and by the CP0 request logic.
package cpu_pipe_pkg;

  localparam int EXC_CODE_W     = 5;
  localparam int TNEW_W_DEFAULT = 3;

  localparam logic [EXC_CODE_W-1:0] EXC_INT  = 5'd0;
  localparam logic [EXC_CODE_W-1:0] EXC_ADEL = 5'd4;
  localparam logic [EXC_CODE_W-1:0] EXC_ADES = 5'd5;
  localparam logic [EXC_CODE_W-1:0] EXC_RI   = 5'd10;
  localparam logic [EXC_CODE_W-1:0] EXC_OV   = 5'd12;

endpackage

// File: rtl/exc_merge.sv
// First-wins exception selector: an older (upstream) exception masks one raised locally.
// Purely combinational, no flow control.
module exc_merge
  import cpu_pipe_pkg::*;
#(
  parameter int EXC_W = EXC_CODE_W
) (
  input  logic             up_valid,
  input  logic [EXC_W-1:0] up_code,
  input  logic             loc_valid,
  input  logic [EXC_W-1:0] loc_code,
  output logic             merged_valid,
  output logic [EXC_W-1:0] merged_code
);

  always_comb begin
    merged_valid = 1'b0;
    merged_code  = '0;
    if (up_valid) begin
      merged_valid = 1'b1;
      merged_code  = up_code;
    end else if (loc_valid) begin
      merged_valid = 1'b1;
      merged_code  = loc_code;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with Tnew countdown and merged exception; 1-cycle latency.
// No ready back-pressure: stall holds contents, bubble empties the slot but keeps PC/BD for EPC.
module pipe_stage_reg
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W           = 256,
  parameter int TNEW_W           = TNEW_W_DEFAULT,
  parameter int EXC_W            = EXC_CODE_W,
  parameter bit TNEW_DEC_ON_HOLD = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              bubble,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_payload,
  input  logic [31:0]       in_pc,
  input  logic              in_bd,
  input  logic [TNEW_W-1:0] in_tnew,
  input  logic              in_exc_valid,
  input  logic [EXC_W-1:0]  in_exc_code,
  input  logic              loc_exc_valid,
  input  logic [EXC_W-1:0]  loc_exc_code,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_payload,
  output logic [31:0]       out_pc,
  output logic              out_bd,
  output logic [TNEW_W-1:0] out_tnew,
  output logic              out_tnew_zero,
  output logic              out_exc_valid,
  output logic [EXC_W-1:0]  out_exc_code
);

  logic             merged_valid;
  logic [EXC_W-1:0] merged_code;
  logic [TNEW_W-1:0] load_tnew;

  exc_merge #(
    .EXC_W (EXC_W)
  ) u_exc_merge (
    .up_valid     (in_exc_valid),
    .up_code      (in_exc_code),
    .loc_valid    (loc_exc_valid),
    .loc_code     (loc_exc_code),
    .merged_valid (merged_valid),
    .merged_code  (merged_code)
  );

  // Saturating decrement; an empty slot carries no pending result.
  always_comb begin
    load_tnew = '0;
    if (in_valid && (in_tnew != '0)) begin
      load_tnew = in_tnew - TNEW_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      out_valid     <= 1'b0;
      out_payload   <= '0;
      out_pc        <= '0;
      out_bd        <= 1'b0;
      out_tnew      <= '0;
      out_exc_valid <= 1'b0;
      out_exc_code  <= '0;
    end else if (bubble) begin
      out_valid     <= 1'b0;
      out_payload   <= '0;
      out_pc        <= in_pc;
      out_bd        <= in_bd;
      out_tnew      <= '0;
      out_exc_valid <= 1'b0;
      out_exc_code  <= '0;
    end else if (stall) begin
      if (TNEW_DEC_ON_HOLD && (out_tnew != '0)) begin
        out_tnew <= out_tnew - TNEW_W'(1);
      end
    end else begin
      out_valid     <= in_valid;
      out_payload   <= in_payload;
      out_pc        <= in_pc;
      out_bd        <= in_bd;
      out_tnew      <= load_tnew;
      out_exc_valid <= in_valid & merged_valid;
      out_exc_code  <= in_valid ? merged_code : '0;
    end
  end

  assign out_tnew_zero = out_valid && (out_tnew == '0);

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the 5-stage MIPS core, replacing the per-stage D/E/M/W register files with one reusable block. It latches an opaque payload bus plus the fields the hazard and exception logic interpret: valid, PC, delay-slot flag, Tnew countdown and a first-wins exception code. It supports hold (stall), full flush (exception/eret) and bubble insertion that keeps PC/BD so EPC stays correct on empty slots.

## Interface
- DATA_W, 256, width of opaque payload (datapath values + control signals)
- TNEW_W, 3, width of Tnew field
- EXC_W, 5, width of CP0 ExcCode
- TNEW_DEC_ON_HOLD, 0, 1 = Tnew also counts down while the stage is held
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- stall  in  1  hold current contents
- flush  in  1  clear everything, including PC/BD
- bubble  in  1  clear instruction, keep PC/BD
- in_valid  in  1  incoming slot holds an instruction
- in_payload  in  DATA_W  opaque payload
- in_pc  in  32  instruction PC
- in_bd  in  1  instruction is in a delay slot
- in_tnew  in  TNEW_W  Tnew as seen in the previous stage
- in_exc_valid / in_exc_code  in  1 / EXC_W  exception raised upstream
- loc_exc_valid / loc_exc_code  in  1 / EXC_W  exception raised in the previous stage this cycle
- out_valid, out_payload, out_pc, out_bd  out  1, DATA_W, 32, 1  registered copies
- out_tnew  out  TNEW_W  registered Tnew
- out_tnew_zero  out  1  out_valid & (out_tnew==0): result is forwardable
- out_exc_valid / out_exc_code  out  1 / EXC_W  merged exception

## Operation
- Priority each clock edge: reset > flush > bubble > stall > load.
- reset or flush: every output is 0.
- bubble: out_valid, out_payload, out_tnew and out_exc_* go to 0. out_pc and out_bd load in_pc and in_bd.
- stall: all fields hold. Exception: if TNEW_DEC_ON_HOLD=1 and out_tnew>0, out_tnew decrements by 1.
- load: every field takes its in_* value. out_tnew = (in_tnew>0) ? in_tnew-1 : 0, i.e. saturating decrement with no wrap below 0.
- Exception merge on load, first wins: if in_exc_valid, take in_exc_code. Else if loc_exc_valid, take loc_exc_code. Else out_exc_valid=0 and code=0.
- If in_valid=0 on load, out_exc_valid is forced to 0 and out_tnew to 0. The payload is still latched.
- out_tnew_zero is combinational from the registered state only.

## Timing
- Latency: 1 cycle from in_* to out_*. No combinational path from inputs to outputs.
- Reset values: all outputs 0, including out_tnew_zero.
- Simultaneous stall+bubble: bubble wins. The stage is then empty, with PC taken from the input.
- Simultaneous flush+stall: flush wins.
- Reset asserted mid-hold: the next edge clears all fields. Hold resumes only after reset deasserts, and then holds the cleared state.
- Tnew at max value (2^TNEW_W-1): it decrements normally, with no overflow path.

## Structure
- Shared package cpu_pipe_pkg: EXC_W, the ExcCode constants (Int=0, AdEL=4, AdES=5, RI=10, Ov=12), and the TNEW_W default.
- Sub-module exc_merge: combinational first-wins selector for the two exception sources. It is reused by the CP0 request logic.
- Per-stage instances (D, E, M, W) differ only in parameters and payload packing.

## Test plan
- Reset: hold reset 2 cycles with all inputs at 1 -> every output is 0 and out_tnew_zero=0.
- Load and Tnew: in_valid=1, in_tnew=2, in_pc=0x3000 -> out_tnew=1 and out_pc=0x3000. Reload with in_tnew=0 -> out_tnew=0 and out_tnew_zero=1.
- Stall: load in_tnew=3 (out_tnew=2), then stall 3 cycles -> with TNEW_DEC_ON_HOLD=0, out_tnew stays 2. With TNEW_DEC_ON_HOLD=1, out_tnew goes 1, 0, 0.
- Bubble vs flush: in_pc=0x3008 and in_bd=1 with bubble -> out_valid=0, out_pc=0x3008, out_bd=1. The same stimulus with flush -> out_pc=0 and out_bd=0.
- Exception merge: in_exc=(1,4) with loc_exc=(1,12) -> out code 4. in_exc=(0,x) with loc_exc=(1,12) -> out code 12. in_valid=0 -> out_exc_valid=0.
- Priority: stall=1, bubble=1, flush=1 in the same cycle -> all outputs 0. Drop flush only -> bubble behaviour.
